// File: rtl/pzcorebus_packer_response_unpacker.sv
`default_nettype none
//==============================================================================
// Module   : pzcorebus_packer_response_unpacker
// Purpose  : Buffers wide (packed) response beats in a register FIFO and
//            splits each buffered beat into narrow sub-word beats, emitting
//            only the sub-words whose unit-enable bit is set. ID, error and
//            last are carried across unchanged.
// Ports    : i_clk, i_rst (sync, active-high), i_clear (sync flush)
//            o_fifo_empty / o_fifo_full      - FIFO occupancy flags
//            i_wide_*  / o_wide_accept       - downstream response input
//            o_narrow_* / i_narrow_accept    - upstream response output
// Revision : 1.0 - initial release
//==============================================================================
module pzcorebus_packer_response_unpacker #(
    parameter int NARROW_WIDTH = 32,
    parameter int RATIO        = 4,
    parameter int ID_WIDTH     = 8,
    parameter int DEPTH        = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    output logic                          o_fifo_empty,
    output logic                          o_fifo_full,
    input  logic                          i_wide_valid,
    output logic                          o_wide_accept,
    input  logic [ID_WIDTH-1:0]           i_wide_id,
    input  logic                          i_wide_error,
    input  logic [RATIO*NARROW_WIDTH-1:0] i_wide_data,
    input  logic [RATIO-1:0]              i_wide_unit_enable,
    input  logic                          i_wide_last,
    output logic                          o_narrow_valid,
    input  logic                          i_narrow_accept,
    output logic [ID_WIDTH-1:0]           o_narrow_id,
    output logic                          o_narrow_error,
    output logic [NARROW_WIDTH-1:0]       o_narrow_data,
    output logic                          o_narrow_last
);

    localparam int c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int c_WIDE_W = RATIO * NARROW_WIDTH;

    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [RATIO-1:0]   c_UE_ONE   = RATIO'(1);

    // Entry storage (payload is intentionally not reset)
    logic [ID_WIDTH-1:0] r_id_q   [DEPTH];
    logic                r_err_q  [DEPTH];
    logic [c_WIDE_W-1:0] r_data_q [DEPTH];
    logic [RATIO-1:0]    r_ue_q   [DEPTH];
    logic                r_last_q [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  r_count_d;
    logic [RATIO-1:0]   r_done_q,   r_done_d;

    logic                w_push;
    logic                w_pop;
    logic                w_narrow_hs;
    logic                w_flush;
    logic [RATIO-1:0]    w_wr_ue;
    logic [RATIO-1:0]    w_remaining;
    logic                w_single;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_WIDE_W-1:0] w_head_data;

    //--------------------------------------------------------------------------
    // Occupancy flags and handshakes
    //--------------------------------------------------------------------------
    assign o_fifo_empty  = (r_count_q == '0);
    assign o_fifo_full   = (r_count_q == c_FULL_CNT);
    assign o_wide_accept = !o_fifo_full && !i_rst;
    assign o_narrow_valid = !o_fifo_empty;

    assign w_flush     = i_rst || i_clear;
    assign w_push      = i_wide_valid && o_wide_accept;
    assign w_narrow_hs = o_narrow_valid && i_narrow_accept;
    assign w_pop       = w_narrow_hs && w_single;

    // An all-zero enable still has to produce one beat (error-only response)
    assign w_wr_ue = (i_wide_unit_enable == '0) ? c_UE_ONE : i_wide_unit_enable;

    //--------------------------------------------------------------------------
    // Head-entry unpacking
    //--------------------------------------------------------------------------
    assign w_head_data = r_data_q[r_rd_ptr_q];
    assign w_remaining = r_ue_q[r_rd_ptr_q] & ~r_done_q;

    // Exactly one bit left: x & (x-1) clears the lowest set bit
    assign w_single = (w_remaining != '0) &&
                      ((w_remaining & (w_remaining - c_UE_ONE)) == '0);

    // Lowest set bit of the remaining mask
    always_comb begin
        w_idx = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (w_remaining[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    assign o_narrow_id    = r_id_q[r_rd_ptr_q];
    assign o_narrow_error = r_err_q[r_rd_ptr_q];
    assign o_narrow_data  = w_head_data[w_idx*NARROW_WIDTH +: NARROW_WIDTH];
    assign o_narrow_last  = r_last_q[r_rd_ptr_q] && w_single;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        r_wr_ptr_d = r_wr_ptr_q;
        r_rd_ptr_d = r_rd_ptr_q;
        r_count_d  = r_count_q;
        r_done_d   = r_done_q;

        if (w_flush) begin
            r_wr_ptr_d = '0;
            r_rd_ptr_d = '0;
            r_count_d  = '0;
            r_done_d   = '0;
        end else begin
            if (w_push) begin
                r_wr_ptr_d = (r_wr_ptr_q == c_LAST_PTR) ? '0 : r_wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr_d = (r_rd_ptr_q == c_LAST_PTR) ? '0 : r_rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count_d = r_count_q + c_CNT_ONE;
                2'b01:   r_count_d = r_count_q - c_CNT_ONE;
                default: r_count_d = r_count_q;
            endcase
            if (w_narrow_hs) begin
                r_done_d = w_single ? '0 : (r_done_q | (c_UE_ONE << w_idx));
            end
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_done_q   <= '0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_count_q  <= r_count_d;
            r_done_q   <= r_done_d;
        end
    end

    // Payload write; a flush cycle discards the push
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) begin
            r_id_q[r_wr_ptr_q]   <= i_wide_id;
            r_err_q[r_wr_ptr_q]  <= i_wide_error;
            r_data_q[r_wr_ptr_q] <= i_wide_data;
            r_ue_q[r_wr_ptr_q]   <= w_wr_ue;
            r_last_q[r_wr_ptr_q] <= i_wide_last;
        end
    end

endmodule
`default_nettype wire
